// File: rtl/basic_cpu_control_unit.sv
// Hardwired control unit for the 16-bit basic computer.
//
// This block owns the sequence counter (sc), the interrupt-cycle flip-flop (r),
// the interrupt enable (ien) and the run flip-flop. Every datapath strobe is a
// combinational decode of that registered state, the current IR and the status
// inputs. The datapath acts on the strobes at the next rising clk.
//
// Ports:
//   clk, clr          clock (rising edge), asynchronous active-high reset
//   ir                current IR contents; ir[15] = I, ir[14:12] = D
//   ac_sign, ac_zero  AC status
//   e_flag, dr_zero   E flip-flop and DR==0 status
//   fgi, fgo          I/O flags
//   bus_sel           bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory
//   ar_*, pc_*, dr_*  register strobes
//   ir_ld, tr_ld, outr_ld, mem_write
//   ac_op, e_op       AC / E operation selects
//   fgi_clr, fgo_clr  flag clears
//   sc, r, ien, running  registered control state
module basic_cpu_control_unit #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [WORD_W-1:0] ir,
    input  logic              ac_sign,
    input  logic              ac_zero,
    input  logic              e_flag,
    input  logic              dr_zero,
    input  logic              fgi,
    input  logic              fgo,
    output logic [2:0]        bus_sel,
    output logic              ar_ld,
    output logic              ar_inr,
    output logic              ar_clr,
    output logic              pc_ld,
    output logic              pc_inr,
    output logic              pc_clr,
    output logic              dr_ld,
    output logic              dr_inr,
    output logic              ir_ld,
    output logic              tr_ld,
    output logic              outr_ld,
    output logic              mem_write,
    output logic [3:0]        ac_op,
    output logic [1:0]        e_op,
    output logic              fgi_clr,
    output logic              fgo_clr,
    output logic [2:0]        sc,
    output logic              r,
    output logic              ien,
    output logic              running
);

    typedef enum logic [2:0] {StT0, StT1, StT2, StT3, StT4, StT5, StT6, StBad} sc_e;

    localparam logic [2:0] BusNone = 3'd0;
    localparam logic [2:0] BusAr   = 3'd1;
    localparam logic [2:0] BusPc   = 3'd2;
    localparam logic [2:0] BusDr   = 3'd3;
    localparam logic [2:0] BusAc   = 3'd4;
    localparam logic [2:0] BusIr   = 3'd5;
    localparam logic [2:0] BusTr   = 3'd6;
    localparam logic [2:0] BusMem  = 3'd7;

    localparam logic [3:0] AcAnd = 4'd1;
    localparam logic [3:0] AcAdd = 4'd2;
    localparam logic [3:0] AcLda = 4'd3;
    localparam logic [3:0] AcClr = 4'd4;
    localparam logic [3:0] AcCma = 4'd5;
    localparam logic [3:0] AcCir = 4'd6;
    localparam logic [3:0] AcCil = 4'd7;
    localparam logic [3:0] AcInc = 4'd8;
    localparam logic [3:0] AcInp = 4'd9;

    localparam logic [1:0] EClr = 2'd1;
    localparam logic [1:0] ECme = 2'd2;

    sc_e  sc_q, sc_d;
    logic r_q, r_d;
    logic ien_q, ien_d;
    logic run_q, run_d;

    logic [2:0]        d;
    logic              ind;
    logic [ADDR_W-1:0] op;

    assign d   = ir[WORD_W-2:WORD_W-4];
    assign ind = ir[WORD_W-1];
    assign op  = ir[ADDR_W-1:0];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sc_q  <= StT0;
            r_q   <= 1'b0;
            ien_q <= 1'b0;
            run_q <= 1'b1;
        end else begin
            sc_q  <= sc_d;
            r_q   <= r_d;
            ien_q <= ien_d;
            run_q <= run_d;
        end
    end

    always_comb begin
        bus_sel   = BusNone;
        ar_ld     = 1'b0;
        ar_inr    = 1'b0;
        ar_clr    = 1'b0;
        pc_ld     = 1'b0;
        pc_inr    = 1'b0;
        pc_clr    = 1'b0;
        dr_ld     = 1'b0;
        dr_inr    = 1'b0;
        ir_ld     = 1'b0;
        tr_ld     = 1'b0;
        outr_ld   = 1'b0;
        mem_write = 1'b0;
        ac_op     = 4'd0;
        e_op      = 2'd0;
        fgi_clr   = 1'b0;
        fgo_clr   = 1'b0;
        sc_d      = sc_e'(sc_q + 3'd1);
        r_d       = r_q;
        ien_d     = ien_q;
        run_d     = run_q;

        if (clr || !run_q) begin
            // Halted (or in reset): everything frozen, no strobes.
            sc_d = sc_q;
        end else begin
            case (sc_q)
                StT0: begin
                    if (r_q) begin
                        ar_clr  = 1'b1;
                        bus_sel = BusPc;
                        tr_ld   = 1'b1;
                    end else begin
                        bus_sel = BusPc;
                        ar_ld   = 1'b1;
                    end
                end
                StT1: begin
                    if (r_q) begin
                        bus_sel   = BusTr;
                        mem_write = 1'b1;
                        pc_clr    = 1'b1;
                    end else begin
                        bus_sel = BusMem;
                        ir_ld   = 1'b1;
                        pc_inr  = 1'b1;
                    end
                end
                StT2: begin
                    if (r_q) begin
                        pc_inr = 1'b1;
                        ien_d  = 1'b0;
                        r_d    = 1'b0;
                        sc_d   = StT0;
                    end else begin
                        bus_sel = BusIr;
                        ar_ld   = 1'b1;
                    end
                end
                StT3: begin
                    if (d == 3'd7) begin
                        sc_d = StT0;
                        if (!ind) begin
                            // Register reference; AC ops resolved by priority.
                            if (op[11])      ac_op = AcClr;
                            else if (op[9])  ac_op = AcCma;
                            else if (op[7])  ac_op = AcCir;
                            else if (op[6])  ac_op = AcCil;
                            else if (op[5])  ac_op = AcInc;
                            if (op[10])      e_op = EClr;
                            else if (op[8])  e_op = ECme;
                            pc_inr = (op[4] && !ac_sign) || (op[3] && ac_sign) ||
                                     (op[2] && ac_zero) || (op[1] && !e_flag);
                            if (op[0]) begin
                                // Halting holds sc at the halting step.
                                run_d = 1'b0;
                                sc_d  = sc_q;
                            end
                        end else begin
                            if (op[11]) begin
                                ac_op   = AcInp;
                                fgi_clr = 1'b1;
                            end
                            if (op[10]) begin
                                bus_sel = BusAc;
                                outr_ld = 1'b1;
                                fgo_clr = 1'b1;
                            end
                            pc_inr = (op[9] && fgi) || (op[8] && fgo);
                            if (op[6])      ien_d = 1'b0;
                            else if (op[7]) ien_d = 1'b1;
                        end
                    end else if (ind) begin
                        bus_sel = BusMem;
                        ar_ld   = 1'b1;
                    end
                end
                StT4: begin
                    unique case (d)
                        3'd0, 3'd1, 3'd2, 3'd6: begin
                            bus_sel = BusMem;
                            dr_ld   = 1'b1;
                        end
                        3'd3: begin
                            bus_sel   = BusAc;
                            mem_write = 1'b1;
                            sc_d      = StT0;
                        end
                        3'd4: begin
                            bus_sel = BusAr;
                            pc_ld   = 1'b1;
                            sc_d    = StT0;
                        end
                        3'd5: begin
                            bus_sel   = BusPc;
                            mem_write = 1'b1;
                            ar_inr    = 1'b1;
                        end
                        default: sc_d = StT0;
                    endcase
                end
                StT5: begin
                    unique case (d)
                        3'd0: begin ac_op = AcAnd; sc_d = StT0; end
                        3'd1: begin ac_op = AcAdd; sc_d = StT0; end
                        3'd2: begin ac_op = AcLda; sc_d = StT0; end
                        3'd5: begin
                            bus_sel = BusAr;
                            pc_ld   = 1'b1;
                            sc_d    = StT0;
                        end
                        3'd6:    dr_inr = 1'b1;
                        default: sc_d = StT0;
                    endcase
                end
                StT6: begin
                    if (d == 3'd6) begin
                        bus_sel   = BusDr;
                        mem_write = 1'b1;
                        pc_inr    = dr_zero;
                    end
                    sc_d = StT0;
                end
                default: sc_d = StT0;  // illegal count: recover without strobes
            endcase

            // Interrupt request is only sampled outside the fetch/interrupt steps.
            if (sc_q != StT0 && sc_q != StT1 && sc_q != StT2 && ien_q && (fgi || fgo)) begin
                r_d = 1'b1;
            end
        end
    end

    assign sc      = sc_q;
    assign r       = r_q;
    assign ien     = ien_q;
    assign running = run_q;

endmodule
